// File: rtl/ecc_pt_unload.sv
// ecc_pt_unload: snapshots the P2 affine point {x, y} on a start request and
// streams it out MSW first (x then y) over a valid/ready word interface.
module ecc_pt_unload #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_start,
  input  logic              rd_abort,
  input  logic [255:0]      ecp2_x,
  input  logic [255:0]      ecp2_y,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic [5:0]        rd_idx,
  output logic              rd_busy,
  output logic              rd_done
);

  // Words per unload and the index of the final (y LSW) word.
  localparam int         N        = 512 / WORD_W;
  localparam logic [5:0] LAST_IDX = 6'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [511:0] shadow_q, shadow_d;
  logic [5:0]   idx_q, idx_d;
  logic         valid_q, last_q, done_q, busy_q;
  logic         xfer;

  // A word moves only while presenting data and the sink is ready.
  assign xfer = (state_q == SEND) && rd_ready;

  // Next-state, shadow and index computation; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    if (rd_abort) begin
      state_d  = IDLE;
      shadow_d = '0;
      idx_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rd_start) begin
            state_d  = SEND;
            shadow_d = {ecp2_x, ecp2_y};
            idx_d    = '0;
          end
        end
        SEND: begin
          if (xfer) begin
            shadow_d = shadow_q << WORD_W;
            idx_d    = idx_q + 6'd1;
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d  = IDLE;
          shadow_d = '0;
          idx_d    = '0;
        end
      endcase
    end
  end

  // State, shadow and registered status outputs, decoded from the next state
  // so every output is a flop and none depends combinationally on rd_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      valid_q  <= (state_d == SEND);
      last_q   <= (state_d == SEND) && (idx_d == LAST_IDX);
      done_q   <= (state_d == DONE);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign rd_data  = shadow_q[511 -: WORD_W];
  assign rd_idx   = idx_q;
  assign rd_valid = valid_q;
  assign rd_last  = last_q;
  assign rd_done  = done_q;
  assign rd_busy  = busy_q;

endmodule

// File: tb/tb_ecc_pt_unload.sv
// Testbench for ecc_pt_unload: scoreboard of expected words filled at start,
// drained against transfers captured by a monitor.
module tb_ecc_pt_unload;

  localparam int W = 32;
  localparam int N = 512 / W;

  logic         clk;
  logic         rst_n;
  logic         rd_start;
  logic         rd_abort;
  logic [255:0] ecp2_x;
  logic [255:0] ecp2_y;
  logic         rd_ready;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         rd_last;
  logic [5:0]   rd_idx;
  logic         rd_busy;
  logic         rd_done;

  typedef struct {
    logic [W-1:0] data;
    logic [5:0]   idx;
    logic         last;
  } obs_t;

  logic [W-1:0] exp_q[$];
  obs_t         obs_q[$];
  int           done_cnt;
  int           n_chk;
  int           n_fail;

  ecc_pt_unload #(.WORD_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_start (rd_start),
    .rd_abort (rd_abort),
    .ecp2_x   (ecp2_x),
    .ecp2_y   (ecp2_y),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_last  (rd_last),
    .rd_idx   (rd_idx),
    .rd_busy  (rd_busy),
    .rd_done  (rd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: capture every transfer and count done pulses.
  always @(posedge clk) begin
    if (rd_valid && rd_ready) begin
      obs_q.push_back('{data: rd_data, idx: rd_idx, last: rd_last});
    end
    if (rd_done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drive a start pulse (called at a negedge) and push the expected stream.
  task automatic do_start(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] s;
    s = {x, y};
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(s[511 -: W]);
      s = s << W;
    end
    ecp2_x   = x;
    ecp2_y   = y;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (rd_data !== '0)    begin n_fail++; $display("FAIL reset_data: got %h, expected 0", rd_data); end
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", rd_valid); end
    n_chk++; if (rd_last !== 1'b0)  begin n_fail++; $display("FAIL reset_last: got %b, expected 0", rd_last); end
    n_chk++; if (rd_idx !== 6'd0)   begin n_fail++; $display("FAIL reset_idx: got %0d, expected 0", rd_idx); end
    n_chk++; if (rd_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", rd_busy); end
    n_chk++; if (rd_done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b, expected 0", rd_done); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (rd_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b, expected 0", rd_busy); end
  endtask

  task automatic test_basic();
    logic [255:0] x, y;
    logic [W-1:0] ew;
    for (int i = 0; i < 8; i++) begin
      x[i*32 +: 32] = 32'(i);
      y[i*32 +: 32] = 32'(i + 8);
    end
    rd_ready = 1'b1;
    do_start(x, y);
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      ew = (k < 8) ? W'(7 - k) : W'(23 - k);
      n_chk++;
      if (rd_valid !== 1'b1 || rd_data !== ew || rd_idx !== 6'(k) || rd_last !== (k == N - 1) || rd_done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_cycle%0d: valid=%b data=%h idx=%0d last=%b done=%b, expected valid=1 data=%h idx=%0d last=%b done=0",
                 k + 1, rd_valid, rd_data, rd_idx, rd_last, rd_done, ew, k, (k == N - 1));
      end
      @(negedge clk);
    end
    n_chk++; if (rd_done !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_done: done=%b valid=%b, expected done=1 valid=0", rd_done, rd_valid); end
    @(negedge clk);
    n_chk++; if (rd_busy !== 1'b0 || rd_done !== 1'b0) begin n_fail++; $display("FAIL basic_idle: busy=%b done=%b, expected 0 0", rd_busy, rd_done); end
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [255:0] x, y;
    logic         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic         stalled;
    logic [W-1:0] sd, e;
    logic [5:0]   si;
    int           d0, cyc;
    obs_t         o;
    for (int i = 0; i < 8; i++) begin
      x[i*32 +: 32] = 32'(i);
      y[i*32 +: 32] = 32'(i + 8);
    end
    d0 = done_cnt;
    stalled = 1'b0;
    do_start(x, y);
    cyc = 0;
    while (done_cnt == d0 && cyc < 200) begin
      if (stalled && rd_valid) begin
        n_chk++;
        if (rd_data !== sd || rd_idx !== si) begin
          n_fail++; $display("FAIL bp_hold: data=%h idx=%0d, expected data=%h idx=%0d", rd_data, rd_idx, sd, si);
        end
      end
      rd_ready = pat[cyc % 4];
      stalled  = rd_valid && !rd_ready;
      sd = rd_data;
      si = rd_idx;
      cyc++;
      @(negedge clk);
    end
    rd_ready = 1'b1;
    n_chk++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL bp_done: done pulses=%0d, expected 1", done_cnt - d0); end
    n_chk++; if (obs_q.size() != N) begin n_fail++; $display("FAIL bp_count: got %0d transfers, expected %0d", obs_q.size(), N); end
    for (int k = 0; k < N; k++) begin
      if (obs_q.size() == 0 || exp_q.size() == 0) break;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++;
      if (o.data !== e || o.idx !== 6'(k) || o.last !== (k == N - 1)) begin
        n_fail++; $display("FAIL bp_word%0d: data=%h idx=%0d last=%b, expected data=%h idx=%0d", k, o.data, o.idx, o.last, e, k);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_snapshot();
    logic [W-1:0] e;
    int   d0;
    obs_t o;
    rd_ready = 1'b1;
    d0 = done_cnt;
    do_start(rnd256(), rnd256());
    @(negedge clk);
    ecp2_x = '1;
    for (int c = 0; c < 100 && done_cnt == d0; c++) @(negedge clk);
    n_chk++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL snap_done: done pulses=%0d, expected 1", done_cnt - d0); end
    n_chk++; if (obs_q.size() != N) begin n_fail++; $display("FAIL snap_count: got %0d words, expected %0d", obs_q.size(), N); end
    for (int k = 0; k < N; k++) begin
      if (obs_q.size() == 0 || exp_q.size() == 0) break;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++;
      if (o.data !== e || o.idx !== 6'(k)) begin
        n_fail++; $display("FAIL snap_word%0d: data=%h idx=%0d, expected data=%h idx=%0d", k, o.data, o.idx, e, k);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_start_busy();
    logic [255:0] x, y;
    logic [W-1:0] e;
    int   d0;
    obs_t o;
    rd_ready = 1'b1;
    x = rnd256(); y = rnd256();
    d0 = done_cnt;
    do_start(x, y);
    for (int c = 0; c < 50 && rd_idx != 6'd5; c++) @(negedge clk);
    n_chk++; if (rd_idx !== 6'd5) begin n_fail++; $display("FAIL busy_reach: idx=%0d, expected 5", rd_idx); end
    ecp2_x = ~x; ecp2_y = ~y; rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    for (int c = 0; c < 100 && done_cnt == d0; c++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL busy_done: done pulses=%0d, expected 1", done_cnt - d0); end
    n_chk++; if (rd_busy !== 1'b0) begin n_fail++; $display("FAIL busy_restart: busy=%b, expected 0", rd_busy); end
    n_chk++; if (obs_q.size() != N) begin n_fail++; $display("FAIL busy_count: got %0d words, expected %0d", obs_q.size(), N); end
    for (int k = 0; k < N; k++) begin
      if (obs_q.size() == 0 || exp_q.size() == 0) break;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++;
      if (o.data !== e || o.idx !== 6'(k)) begin
        n_fail++; $display("FAIL busy_word%0d: data=%h idx=%0d, expected data=%h idx=%0d", k, o.data, o.idx, e, k);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_abort();
    logic [W-1:0] e;
    int   d0;
    obs_t o;
    rd_ready = 1'b1;
    d0 = done_cnt;
    do_start(rnd256(), rnd256());
    for (int c = 0; c < 50 && rd_idx != 6'd9; c++) @(negedge clk);
    n_chk++; if (rd_idx !== 6'd9) begin n_fail++; $display("FAIL abort_reach: idx=%0d, expected 9", rd_idx); end
    rd_abort = 1'b1;
    @(negedge clk);
    rd_abort = 1'b0;
    n_chk++;
    if (rd_valid !== 1'b0 || rd_busy !== 1'b0 || rd_idx !== 6'd0 || rd_done !== 1'b0 || rd_data !== '0) begin
      n_fail++; $display("FAIL abort_state: valid=%b busy=%b idx=%0d done=%b data=%h, expected all 0", rd_valid, rd_busy, rd_idx, rd_done, rd_data);
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (done_cnt !== d0) begin n_fail++; $display("FAIL abort_nodone: done pulses=%0d, expected 0", done_cnt - d0); end
    n_chk++; if (obs_q.size() < 9) begin n_fail++; $display("FAIL abort_count: got %0d words, expected at least 9", obs_q.size()); end
    for (int k = 0; k < 9; k++) begin
      if (obs_q.size() == 0 || exp_q.size() == 0) break;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++;
      if (o.data !== e || o.idx !== 6'(k)) begin
        n_fail++; $display("FAIL abort_word%0d: data=%h idx=%0d, expected data=%h idx=%0d", k, o.data, o.idx, e, k);
      end
    end
    exp_q.delete(); obs_q.delete();
    // Abort and start together in IDLE: stays idle.
    rd_start = 1'b1; rd_abort = 1'b1;
    @(negedge clk);
    rd_start = 1'b0; rd_abort = 1'b0;
    n_chk++; if (rd_busy !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL abort_start: busy=%b valid=%b, expected 0 0", rd_busy, rd_valid); end
    @(negedge clk);
    obs_q.delete();
    // Fresh unload after abort.
    d0 = done_cnt;
    do_start(rnd256(), rnd256());
    n_chk++; if (rd_valid !== 1'b1 || rd_idx !== 6'd0) begin n_fail++; $display("FAIL abort_fresh: valid=%b idx=%0d, expected 1 0", rd_valid, rd_idx); end
    for (int c = 0; c < 100 && done_cnt == d0; c++) @(negedge clk);
    n_chk++; if (obs_q.size() != N) begin n_fail++; $display("FAIL abort_fresh_count: got %0d words, expected %0d", obs_q.size(), N); end
    for (int k = 0; k < N; k++) begin
      if (obs_q.size() == 0 || exp_q.size() == 0) break;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++;
      if (o.data !== e || o.idx !== 6'(k)) begin
        n_fail++; $display("FAIL abort_fresh_word%0d: data=%h idx=%0d, expected data=%h idx=%0d", k, o.data, o.idx, e, k);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    int   d0;
    obs_t o;
    rd_ready = 1'b1;
    do_start(rnd256(), rnd256());
    for (int c = 0; c < 50 && rd_idx != 6'd3; c++) @(negedge clk);
    n_chk++; if (rd_idx !== 6'd3) begin n_fail++; $display("FAIL rstmid_reach: idx=%0d, expected 3", rd_idx); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_idx !== 6'd0 || rd_busy !== 1'b0 || rd_done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: data=%h valid=%b last=%b idx=%0d busy=%b done=%b, expected all 0",
                         rd_data, rd_valid, rd_last, rd_idx, rd_busy, rd_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete();
    @(negedge clk);
    n_chk++; if (rd_busy !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: busy=%b valid=%b, expected 0 0", rd_busy, rd_valid); end
    d0 = done_cnt;
    do_start(rnd256(), rnd256());
    n_chk++; if (rd_valid !== 1'b1 || rd_data !== exp_q[0]) begin n_fail++; $display("FAIL rstmid_restart: valid=%b data=%h, expected 1 %h", rd_valid, rd_data, exp_q[0]); end
    for (int c = 0; c < 100 && done_cnt == d0; c++) @(negedge clk);
    n_chk++; if (obs_q.size() != N) begin n_fail++; $display("FAIL rstmid_count: got %0d words, expected %0d", obs_q.size(), N); end
    for (int k = 0; k < N; k++) begin
      if (obs_q.size() == 0 || exp_q.size() == 0) break;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++;
      if (o.data !== e || o.idx !== 6'(k)) begin
        n_fail++; $display("FAIL rstmid_word%0d: data=%h idx=%0d, expected data=%h idx=%0d", k, o.data, o.idx, e, k);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    rd_start = 1'b0;
    rd_abort = 1'b0;
    rd_ready = 1'b0;
    ecp2_x   = '0;
    ecp2_y   = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_start_busy();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
